hazard_scoreboard: RTL and testbench

- Issue-control block between decode and execute in the RISC-V core.
- Consumes decoded fields (opcode, rd, rs1, rs2, 3-bit inst type) for the instruction in ID.
- Tracks register writes from outstanding variable-latency loads in a 32-entry pending scoreboard and stalls ID on RAW/WAW hazards or when the load-tracking limit is reached.
- Generates one-cycle EX->ID forwarding selects for single-cycle (non-load) writers.

---
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage issue control that stalls on RAW/WAW hazards against outstanding loads and selects EX->ID forwarding.
// Optional sticky illegal-write-back flag `err` when SCOREBOARD_ERR_EN is defined. Rev 1.0
`default_nettype none

module hazard_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [2:0]       id_inst_type,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  output logic             id_ready,
  output logic             fwd_rs1,
  output logic             fwd_rs2,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] outstanding,
  output logic             busy
`ifdef SCOREBOARD_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [6:0]       OP_LOAD = 7'h03;

  logic [31:1]      pend;
  logic [CNT_W-1:0] cnt;
  logic             ex_vld_q;
  logic [4:0]       ex_rd_q;

  logic        uses_rs1, uses_rs2, writes_rd, is_load;
  logic [31:0] pend_full;
  logic        hazard, issue, load_issue, load_set, wb_clr;

  always_comb begin
    uses_rs1  = (id_inst_type <= 3'd3);
    uses_rs2  = (id_inst_type == 3'd0) || (id_inst_type == 3'd2) || (id_inst_type == 3'd3);
    writes_rd = ((id_inst_type == 3'd0) || (id_inst_type == 3'd1) ||
                 (id_inst_type == 3'd4) || (id_inst_type == 3'd5)) && (id_rd != 5'd0);
    is_load   = (id_opcode == OP_LOAD);
  end

  // x0 reads as never pending, so no separate x0 qualification is needed in the hazard terms
  assign pend_full = {pend, 1'b0};

  always_comb begin
    hazard = (uses_rs1 & pend_full[id_rs1]) |
             (uses_rs2 & pend_full[id_rs2]) |
             (writes_rd & pend_full[id_rd]) |
             (is_load & (cnt == MAX_CNT));
  end

  assign id_ready   = ~hazard;
  assign issue      = id_valid & id_ready;
  assign load_issue = issue & is_load;
  assign load_set   = load_issue & writes_rd;
  // A write-back with nothing outstanding is ignored entirely
  assign wb_clr     = wb_valid & (cnt != '0);

  for (genvar i = 1; i < 32; i++) begin : g_pend
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend[i] <= 1'b0;
      end else if (load_set && (id_rd == 5'(i))) begin
        pend[i] <= 1'b1;
      end else if (wb_clr && (wb_rd == 5'(i))) begin
        pend[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({load_issue, wb_clr})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q <= 1'b0;
      ex_rd_q  <= 5'd0;
    end else begin
      ex_vld_q <= ~flush & issue & ~is_load & writes_rd;
      if (~flush & issue & ~is_load & writes_rd) begin
        ex_rd_q <= id_rd;
      end
    end
  end

  assign fwd_rs1     = ex_vld_q & uses_rs1 & (id_rs1 == ex_rd_q) & (id_rs1 != 5'd0);
  assign fwd_rs2     = ex_vld_q & uses_rs2 & (id_rs2 == ex_rd_q) & (id_rs2 != 5'd0);
  assign outstanding = cnt;
  assign busy        = (cnt != '0);

`ifdef SCOREBOARD_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (wb_valid && (((wb_rd != 5'd0) && !pend_full[wb_rd]) || (cnt == '0))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with a register-array reference model checked every cycle.
`default_nettype none

module tb_hazard_scoreboard;

  localparam int MAX = 4;
  localparam logic [6:0] LD = 7'h03, OP = 7'h33, OPI = 7'h13, ST = 7'h23, LUI = 7'h37;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       id_valid = 0, wb_valid = 0, flush = 0;
  logic [6:0] id_opcode = 0;
  logic [2:0] id_inst_type = 0;
  logic [4:0] id_rd = 0, id_rs1 = 0, id_rs2 = 0, wb_rd = 0;
  logic       id_ready, fwd_rs1, fwd_rs2, busy;
  logic [3:0] outstanding;
`ifdef SCOREBOARD_ERR_EN
  logic       err;
`endif

  int compared = 0, mismatched = 0;

  hazard_scoreboard #(.MAX_OUTSTANDING(MAX), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_inst_type(id_inst_type), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_ready(id_ready), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .flush(flush), .outstanding(outstanding), .busy(busy)
`ifdef SCOREBOARD_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of pending registers and in-flight loads
  bit pm[32];
  int mcnt;
  bit mexv;
  int mexrd;
  bit merr;

  function automatic bit m_uses1();  return id_inst_type <= 3; endfunction
  function automatic bit m_uses2();  return id_inst_type inside {3'd0, 3'd2, 3'd3}; endfunction
  function automatic bit m_writes(); return (id_inst_type inside {3'd0, 3'd1, 3'd4, 3'd5}) && id_rd != 0; endfunction
  function automatic bit m_ready();
    bit h;
    h = (m_uses1() && pm[id_rs1]) || (m_uses2() && pm[id_rs2]) ||
        (m_writes() && pm[id_rd]) || (id_opcode == LD && mcnt == MAX);
    return !h;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (pm[i]) pm[i] = 0;
      mcnt = 0; mexv = 0; mexrd = 0; merr = 0;
    end else begin
      bit iss, dec;
      iss = id_valid && m_ready();
      dec = 0;
      if (wb_valid) begin
        if ((wb_rd != 0 && !pm[wb_rd]) || mcnt == 0) merr = 1;
        if (mcnt > 0) begin pm[wb_rd] = 0; dec = 1; end
      end
      mexv = !flush && iss && id_opcode != LD && m_writes();
      if (mexv) mexrd = id_rd;
      if (iss && id_opcode == LD) begin
        if (m_writes()) pm[id_rd] = 1;
        mcnt = mcnt + 1;
      end
      if (dec) mcnt = mcnt - 1;
      pm[0] = 0;
    end
  end

  always @(negedge clk) begin
    chk("id_ready", id_ready, m_ready());
    chk("fwd_rs1", fwd_rs1, mexv && m_uses1() && id_rs1 == mexrd && id_rs1 != 0);
    chk("fwd_rs2", fwd_rs2, mexv && m_uses2() && id_rs2 == mexrd && id_rs2 != 0);
    chk("outstanding", outstanding, mcnt);
    chk("busy", busy, mcnt != 0);
`ifdef SCOREBOARD_ERR_EN
    chk("err", err, merr);
`endif
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic set_id(input logic v, input logic [6:0] op, input logic [2:0] ty,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    id_valid = v; id_opcode = op; id_inst_type = ty; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
  endtask
  task automatic idle(); set_id(0, OP, 0, 0, 0, 0); endtask
  task automatic wb(input logic v, input logic [4:0] rd); wb_valid = v; wb_rd = rd; endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #2;
    chk("rst_ready", id_ready, 1); chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0); chk("rst_fwd", fwd_rs1 | fwd_rs2, 0);

    // RAW: lw x5 then add x6,x5,x7
    set_id(1, LD, 1, 5, 0, 0); #2 chk("raw_lw_ready", id_ready, 1);
    step();
    set_id(1, OP, 0, 6, 5, 7); #2 chk("raw_stall", id_ready, 0); chk("raw_cnt", outstanding, 1);
    step(); #2 chk("raw_stall2", id_ready, 0);
    wb(1, 5); #2 chk("raw_wb_cycle", id_ready, 0);
    step(); wb(0, 0); #2
    chk("raw_release", id_ready, 1); chk("raw_cnt0", outstanding, 0); chk("raw_busy0", busy, 0);
    step(); idle();

    // Forwarding: addi x3 then sw rs2=x3; then again with flush on the addi cycle
    set_id(1, OPI, 1, 3, 1, 0); step();
    set_id(1, ST, 2, 0, 4, 3); #2
    chk("fwd_rs2", fwd_rs2, 1); chk("fwd_rs1", fwd_rs1, 0); chk("fwd_ready", id_ready, 1);
    step();
    set_id(1, OPI, 1, 3, 1, 0); flush = 1; step(); flush = 0;
    set_id(1, ST, 2, 0, 4, 3); #2 chk("fwd_flushed", fwd_rs2, 0);
    step(); idle();

    // Tracking limit
    for (int i = 1; i <= 4; i++) begin set_id(1, LD, 1, 5'(i), 0, 0); step(); end
    set_id(1, LD, 1, 9, 0, 0); #2 chk("lim_stall", id_ready, 0); chk("lim_cnt", outstanding, 4);
    wb(1, 2); step(); wb(0, 0); #2
    chk("lim_release", id_ready, 1); chk("lim_cnt3", outstanding, 3);
    wb(1, 3); step(); wb(0, 0); idle(); #2 chk("lim_simul", outstanding, 3);
    wb(1, 1); step(); wb(1, 4); step(); wb(1, 9); step(); wb(0, 0); #2
    chk("lim_drain", outstanding, 0); chk("lim_busy", busy, 0);

    // x0 load, then U-type ignoring its rs fields
    set_id(1, LD, 1, 0, 0, 0); step();
    set_id(1, OP, 0, 1, 0, 0); #2
    chk("x0_ready", id_ready, 1); chk("x0_fwd1", fwd_rs1, 0); chk("x0_fwd2", fwd_rs2, 0);
    chk("x0_cnt", outstanding, 1);
    step();
    set_id(1, LD, 1, 5, 0, 0); step();
    set_id(1, LUI, 4, 8, 5, 5); #2 chk("lui_ready", id_ready, 1);
    step(); idle();
    wb(1, 0); step(); wb(1, 5); step(); wb(0, 0); #2 chk("x0_drain", outstanding, 0);

    // WAW
    set_id(1, LD, 1, 5, 0, 0); step();
    set_id(1, OPI, 1, 5, 1, 0); #2 chk("waw_stall", id_ready, 0);
    step(); #2 chk("waw_stall2", id_ready, 0);
    wb(1, 5); step(); wb(0, 0); #2 chk("waw_release", id_ready, 1);
    step(); idle();

    // Spurious write-back with nothing outstanding
    wb(1, 12); step(); wb(0, 0); #2 chk("spur_cnt", outstanding, 0);
`ifdef SCOREBOARD_ERR_EN
    chk("err_set", err, 1);
    step(); #2 chk("err_sticky", err, 1);
`endif

    // Reset mid-stream with three loads pending
    for (int i = 1; i <= 3; i++) begin set_id(1, LD, 1, 5'(i), 0, 0); step(); end
    idle(); #2 chk("pre_rst_cnt", outstanding, 3);
    rst_n = 0; #1
    chk("async_rst_cnt", outstanding, 0); chk("async_rst_busy", busy, 0);
    step(); rst_n = 1;
    set_id(1, OP, 0, 7, 1, 2); #2 chk("post_rst_ready", id_ready, 1);
`ifdef SCOREBOARD_ERR_EN
    chk("post_rst_err", err, 0);
`endif
    step(); idle();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
